// File: rtl/iddmm_pkg.sv
// Shared definitions for the IDDMM datapath: default geometry, FSM encoding
// and the 4-bit carry-look-ahead primitive reused at every CLA level.
package iddmm_pkg;

    localparam int DEF_WORD   = 64;
    localparam int DEF_NWORDS = 64;
    localparam int CLA_GRP    = 16;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    // Returns carries c[0..4] of a 4-wide generate/propagate slice, flattened.
    function automatic logic [4:0] cla4(input logic [3:0] g,
                                        input logic [3:0] p,
                                        input logic       cin);
        logic [4:0] c;
        c[0] = cin;
        c[1] = g[0] | (p[0] & cin);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
             | (p[2] & p[1] & p[0] & cin);
        c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
             | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & cin);
        return c;
    endfunction

endpackage

// File: rtl/mlclaa_serial_addsub_if.sv
// Stream interface of the word-serial adder/subtractor: operand side in,
// result side out, plus the busy status.
interface mlclaa_serial_addsub_if #(
    parameter int WORD = 64
);
    logic            i_valid;
    logic            i_ready;
    logic            i_sub;
    logic [WORD-1:0] i_a;
    logic [WORD-1:0] i_b;
    logic            o_valid;
    logic            o_ready;
    logic [WORD-1:0] o_sum;
    logic            o_first;
    logic            o_last;
    logic            o_cout;
    logic            o_busy;

    modport master (
        output i_valid, i_sub, i_a, i_b, o_ready,
        input  i_ready, o_valid, o_sum, o_first, o_last, o_cout, o_busy
    );

    modport slave (
        input  i_valid, i_sub, i_a, i_b, o_ready,
        output i_ready, o_valid, o_sum, o_first, o_last, o_cout, o_busy
    );

endinterface

// File: rtl/mlclaa_serial_addsub_word.sv
// Combinational WORD-bit adder: 4-bit CLA inside nibbles, 4-nibble CLA inside
// 16-bit groups, and a flattened look-ahead across the 16-bit groups.
module mlclaa_word
    import iddmm_pkg::*;
#(
    parameter int WORD = DEF_WORD
) (
    input  logic            cin,
    input  logic [WORD-1:0] a,
    input  logic [WORD-1:0] b,
    output logic [WORD-1:0] sum,
    output logic            cout
);

    localparam int NG = WORD / CLA_GRP;
    localparam int NN = WORD / 4;

    logic [WORD-1:0] g, p, c;
    logic [NN-1:0]   ng, np, nc;
    logic [NG-1:0]   gg, gp;
    logic [NG:0]     gc;

    always_comb begin
        logic [4:0] t;
        logic       run_p;
        // NOTE: every combinational output gets a default before any branch or
        // loop writes it, so no path can leave a stale value (no latch).
        g  = a & b;
        p  = a ^ b;
        ng = '0;
        np = '0;
        nc = '0;
        gg = '0;
        gp = '0;
        gc = '0;
        c  = '0;
        t  = '0;
        run_p = 1'b1;

        for (int n = 0; n < NN; n++) begin
            t     = cla4(g[4*n +: 4], p[4*n +: 4], 1'b0);
            ng[n] = t[4];
            np[n] = &p[4*n +: 4];
        end
        for (int k = 0; k < NG; k++) begin
            t     = cla4(ng[4*k +: 4], np[4*k +: 4], 1'b0);
            gg[k] = t[4];
            gp[k] = &np[4*k +: 4];
        end
        // Each group carry is an independent sum-of-products over all lower groups.
        for (int j = 0; j <= NG; j++) begin
            run_p = 1'b1;
            for (int i = j - 1; i >= 0; i--) begin
                gc[j] = gc[j] | (gg[i] & run_p);
                run_p = run_p & gp[i];
            end
            gc[j] = gc[j] | (cin & run_p);
        end
        for (int k = 0; k < NG; k++) begin
            t             = cla4(ng[4*k +: 4], np[4*k +: 4], gc[k]);
            nc[4*k +: 4]  = t[3:0];
        end
        for (int n = 0; n < NN; n++) begin
            t            = cla4(g[4*n +: 4], p[4*n +: 4], nc[n]);
            c[4*n +: 4]  = t[3:0];
        end
    end

    assign sum  = p ^ c;
    assign cout = gc[NG];

endmodule

// File: rtl/mlclaa_serial_addsub.sv
// Word-serial wide add/subtract, LS word first; the inter-word carry lives in a
// register so one word is consumed per beat. o_cout is the borrow when subtracting.
module mlclaa_serial_addsub
    import iddmm_pkg::*;
#(
    parameter int WORD   = DEF_WORD,
    parameter int NWORDS = DEF_NWORDS,
    parameter int CNT_W  = (NWORDS > 1) ? $clog2(NWORDS) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    mlclaa_serial_addsub_if.slave bus
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(NWORDS - 1);

    state_e          state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic            carry_q, carry_d;
    logic            mode_q, mode_d;
    logic            valid_q, valid_d;
    logic [WORD-1:0] sum_q, sum_d;
    logic            first_q, first_d;
    logic            last_q, last_d;
    logic            cout_q, cout_d;

    logic            accept, is_idle, is_last, eff_sub, cin;
    logic [WORD-1:0] b_eff, w_sum;
    logic            w_cout;

    assign bus.i_ready = !valid_q || bus.o_ready;
    assign accept      = bus.i_valid && bus.i_ready;
    assign is_idle     = (state_q == IDLE);
    assign is_last     = (NWORDS == 1) ? 1'b1 : (state_q == RUN && cnt_q == LAST);
    // Subtraction is a + ~b + 1: the +1 enters as the carry-in of word 0 only.
    assign eff_sub     = is_idle ? bus.i_sub : mode_q;
    assign cin         = is_idle ? bus.i_sub : carry_q;
    assign b_eff       = eff_sub ? ~bus.i_b : bus.i_b;

    mlclaa_word #(.WORD(WORD)) u_word (
        .cin  (cin),
        .a    (bus.i_a),
        .b    (b_eff),
        .sum  (w_sum),
        .cout (w_cout)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        mode_d  = mode_q;
        valid_d = valid_q;
        sum_d   = sum_q;
        first_d = first_q;
        last_d  = last_q;
        cout_d  = cout_q;

        if (accept) begin
            mode_d  = eff_sub;
            carry_d = w_cout;
            valid_d = 1'b1;
            sum_d   = w_sum;
            first_d = is_idle;
            last_d  = is_last;
            cout_d  = is_last ? (eff_sub ? ~w_cout : w_cout) : 1'b0;
            if (is_last) begin
                state_d = IDLE;
                cnt_d   = '0;
            end else begin
                state_d = RUN;
                cnt_d   = cnt_q + CNT_W'(1);
            end
        end else if (bus.o_ready) begin
            valid_d = 1'b0;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            mode_q  <= 1'b0;
            valid_q <= 1'b0;
            sum_q   <= '0;
            first_q <= 1'b0;
            last_q  <= 1'b0;
            cout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            mode_q  <= mode_d;
            valid_q <= valid_d;
            sum_q   <= sum_d;
            first_q <= first_d;
            last_q  <= last_d;
            cout_q  <= cout_d;
        end
    end

    assign bus.o_valid = valid_q;
    assign bus.o_sum   = sum_q;
    assign bus.o_first = first_q;
    assign bus.o_last  = last_q;
    assign bus.o_cout  = cout_q;
    assign bus.o_busy  = (state_q == RUN);

endmodule

// File: doc/mlclaa_serial_addsub.md
Name: mlclaa_serial_addsub

Overview:
- Word-serial, wide-operand adder/subtractor for the IDDMM datapath (default 4096-bit operands = 64 words x 64 bits).
- Operands stream least-significant word first. Each word passes through a parametrised multi-level carry-look-ahead word adder.
- The inter-word carry is held in a register, so one word is processed per beat.
- Used for Montgomery accumulation and the final conditional subtraction. The borrow output tells whether a < b.

Parameters:
- WORD, 64, bits per word; must be a multiple of 16.
- NWORDS, 64, words per operation; operand width = WORD*NWORDS; must be >= 1.
- CNT_W, $clog2(NWORDS) (min 1), word counter width.

Ports:
- clk, input, 1, single clock; all logic on rising edge.
- rst, input, 1, synchronous, active-high reset.
- i_valid, input, 1, operand word valid.
- i_ready, output, 1, block accepts word when i_valid & i_ready.
- i_sub, input, 1, 0 = a+b, 1 = a-b; sampled only on first word of an operation.
- i_a, input, WORD, operand A word.
- i_b, input, WORD, operand B word.
- o_valid, output, 1, result word valid.
- o_ready, input, 1, downstream accepts result word.
- o_sum, output, WORD, result word.
- o_first, output, 1, result word is word 0.
- o_last, output, 1, result word is word NWORDS-1.
- o_cout, output, 1, valid only with o_last: add = carry out; sub = borrow (1 iff a < b unsigned).
- o_busy, output, 1, operation in progress (state RUN).

Behaviour:
- Reset (synchronous, active-high; applies in any state, mid-operation included):
  - State IDLE; counter 0; carry register 0; mode register 0.
  - o_valid 0, o_sum 0, o_first 0, o_last 0, o_cout 0, o_busy 0.
  - A partially processed operation is discarded; no output beat follows reset.
- Handshake:
  - i_ready = !o_valid | o_ready (single output register, no bubble under continuous flow).
  - An input beat is accepted iff i_valid & i_ready.
  - o_valid/o_sum/o_first/o_last/o_cout hold stable while o_valid & !o_ready.
- Latency: 1 cycle from accepted input beat to o_valid.
- Throughput: 1 word/cycle when o_ready is high.
- State IDLE: awaiting word 0.
  - On accept: mode <= i_sub. Operand b' = i_sub ? ~i_b : i_b; carry-in = i_sub.
  - If NWORDS==1, stay in IDLE and flag both o_first and o_last. Otherwise go to RUN with counter <= 1.
- State RUN: on accept, use b' = mode ? ~i_b : i_b and carry-in = carry register.
  - When counter == NWORDS-1: flag o_last, counter <= 0, return to IDLE.
  - Otherwise counter increments.
  - i_sub is ignored in RUN.
- Word arithmetic: {c, s} = i_a + b' + cin, full WORD+1 bits.
  - carry register <= c on every accept.
  - o_sum <= s.
  - On the last word, o_cout <= mode ? ~c : c; on other words o_cout <= 0.
- Word adder: 16-bit carry-look-ahead groups.
  - Each 16-bit group has two-level generate/propagate (four 4-bit groups).
  - A third look-ahead level spans groups when WORD > 16.
  - No ripple across more than one group boundary per level.
- Back-to-back operations: word 0 of the next operation may be accepted in the cycle after the last word is accepted. The new i_sub takes effect immediately, and the carry is not carried over.
- i_valid low mid-operation: the counter and carry hold indefinitely; the result is unaffected by gaps.
- Overflow is not flagged beyond o_cout; the result wraps modulo 2^(WORD*NWORDS).

Decomposition:
- Shared package iddmm_pkg holds:
  - constants DEF_WORD = 64 and DEF_NWORDS = 64;
  - the state encoding typedef (IDLE = 0, RUN = 1);
  - CLA group size constant CLA_GRP = 16.
- One sub-module, mlclaa_word:
  - parameter WORD;
  - inputs cin, a, b; outputs sum, cout;
  - purely combinational, multi-level CLA;
  - instantiated once.
- Counter, FSM, mode/carry registers and output register stay in the top.

Test Plan (WORD=16, NWORDS=4):
- Add 0xFFFF_FFFF_FFFF_FFFF + 0x0000_0000_0000_0001, o_ready=1 -> words 0x0000 x4, o_first on beat 0, o_last on beat 3, o_cout=1, one-cycle latency.
- Sub 0x0000_0000_0000_0000 - 0x0000_0000_0000_0001 -> 0xFFFF x4, o_cout=1 (borrow). Sub 0x1234_5678_9ABC_DEF0 - 0x0000_0000_0000_DEF0 -> 0x1234_5678_9ABC_0000, o_cout=0.
- Backpressure: o_ready low for 3 cycles at beat 1 of add 0x0001_0002_0003_0004 + 0x0004_0003_0002_0001 -> i_ready low, o_sum holds 0x0005 stable, final words all 0x0005, o_cout=0.
- Back-to-back: add with final carry (0xFFFF.. + 1) immediately followed by sub 5-3 -> second result 0x0000_0000_0000_0002, o_cout=0 (no carry leakage, i_sub re-sampled).
- Reset mid-operation after 2 words accepted -> o_valid=0 next cycle, o_busy=0; a fresh add 1+1 yields 0x0002,0,0,0 with o_first on word 0 and o_cout=0.
- Random gaps on i_valid/o_ready, 1000 random 64-bit operand pairs per mode -> match reference model sum/difference and carry/borrow.
